load_store_unit: RTL



---
 rtl/lsu_pkg.sv | 48 ++++
 rtl/lsu_lane.sv | 66 ++++++
 rtl/load_store_unit.sv | 141 ++++++++++++++
 3 files changed

// File: rtl/lsu_pkg.sv
// lsu_pkg: shared definitions for the load/store unit.
//   - RV32 funct3 width codes
//   - FSM state encoding
//   - misalignment / illegal-encoding predicates used at request acceptance
package lsu_pkg;

    localparam int XLEN_SUPPORTED = 32;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        ACCESS = 3'd1,
        RMW_RD = 3'd2,
        RMW_WR = 3'd3,
        ERR    = 3'd4,
        RESP   = 3'd5
    } lsu_state_t;

    // Halfwords must be 2-byte aligned, words 4-byte aligned; bytes never misalign.
    function automatic logic is_misaligned(input logic [2:0] funct3, input logic [1:0] offset);
        logic result;
        result = 1'b0;
        case (funct3)
            F3_H, F3_HU: result = offset[0];
            F3_W:        result = (offset != 2'b00);
            default:     result = 1'b0;
        endcase
        return result;
    endfunction

    // 011/110/111 are never legal; stores have no unsigned variants.
    function automatic logic is_illegal(input logic store, input logic [2:0] funct3);
        logic result;
        result = 1'b0;
        case (funct3)
            F3_B, F3_H, F3_W: result = 1'b0;
            F3_BU, F3_HU:     result = store;
            default:          result = 1'b1;
        endcase
        return result;
    endfunction

endpackage

// File: rtl/lsu_lane.sv
// lsu_lane: combinational byte-lane logic for the load/store unit.
// Ports:
//   word      in  32  memory word being read
//   offset    in  2   byte offset within the word (addr[1:0])
//   funct3    in  3   RV32 width code
//   wdata     in  16  low half of the store data (only byte/halfword stores merge)
//   load_data out 32  selected lane, sign- or zero-extended
//   merged    out 32  word with the target byte/halfword lane replaced by wdata
module lsu_lane
    import lsu_pkg::*;
(
    input  logic [31:0] word,
    input  logic [1:0]  offset,
    input  logic [2:0]  funct3,
    input  logic [15:0] wdata,
    output logic [31:0] load_data,
    output logic [31:0] merged
);

    logic [7:0]  sel_byte;
    logic [15:0] sel_half;

    always_comb begin
        sel_byte = 8'h00;
        case (offset)
            2'd0:    sel_byte = word[7:0];
            2'd1:    sel_byte = word[15:8];
            2'd2:    sel_byte = word[23:16];
            default: sel_byte = word[31:24];
        endcase
        // Halfword accesses are aligned by the time they get here, so offset[1] picks the lane.
        sel_half = offset[1] ? word[31:16] : word[15:0];
    end

    always_comb begin
        load_data = 32'h0;
        case (funct3)
            F3_B:    load_data = {{24{sel_byte[7]}}, sel_byte};
            F3_BU:   load_data = {24'h0, sel_byte};
            F3_H:    load_data = {{16{sel_half[15]}}, sel_half};
            F3_HU:   load_data = {16'h0, sel_half};
            F3_W:    load_data = word;
            default: load_data = 32'h0;
        endcase
    end

    always_comb begin
        merged = word;
        case (funct3)
            F3_B: begin
                case (offset)
                    2'd0:    merged[7:0]   = wdata[7:0];
                    2'd1:    merged[15:8]  = wdata[7:0];
                    2'd2:    merged[23:16] = wdata[7:0];
                    default: merged[31:24] = wdata[7:0];
                endcase
            end
            F3_H: begin
                if (offset[1]) merged[31:16] = wdata;
                else           merged[15:0]  = wdata;
            end
            default: merged = word;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// load_store_unit: RV32 load/store initiator for a word-addressed data memory
// with combinational read and write-on-clock-edge.
// Ports:
//   clk_i, rst_i              clock, asynchronous active-high reset
//   req_valid_i/req_ready_o   request handshake
//   req_store_i               1 = store, 0 = load
//   req_funct3_i              RV32 width code
//   req_addr_i, req_wdata_i   byte address, right-aligned store data
//   resp_valid_o              one-cycle response pulse per accepted request
//   resp_rdata_o, resp_err_o  extended load data / error flag, held until next response
//   mem_addr_o                word index = {2'b00, addr[XLEN-1:2]}
//   mem_we_o, mem_wdata_o     memory write strobe and data
//   mem_rdata_i               combinational read data for mem_addr_o
//   dbg_state                 current FSM state (lsu_state_t encoding)
//
// Handshake: a request transfers on a rising edge where req_valid_i and
// req_ready_o are both 1; req_ready_o is 1 only in IDLE, so a request held
// while busy is simply not taken. Responses have no backpressure.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            req_valid_i,
    output logic            req_ready_o,
    input  logic            req_store_i,
    input  logic [2:0]      req_funct3_i,
    input  logic [XLEN-1:0] req_addr_i,
    input  logic [XLEN-1:0] req_wdata_i,
    output logic            resp_valid_o,
    output logic [XLEN-1:0] resp_rdata_o,
    output logic            resp_err_o,
    output logic [XLEN-1:0] mem_addr_o,
    output logic            mem_we_o,
    output logic [XLEN-1:0] mem_wdata_o,
    input  logic [XLEN-1:0] mem_rdata_i,
    output logic [2:0]      dbg_state
);

    lsu_state_t      state;
    logic            store_q;
    logic [2:0]      funct3_q;
    logic [XLEN-1:0] addr_q;
    logic [XLEN-1:0] wdata_q;

    logic [XLEN-1:0] load_data;
    logic [XLEN-1:0] merged;

    lsu_lane u_lane (
        .word      (mem_rdata_i),
        .offset    (addr_q[1:0]),
        .funct3    (funct3_q),
        .wdata     (wdata_q[15:0]),
        .load_data (load_data),
        .merged    (merged)
    );

    // Address comes only from the latched request, never from req_addr_i.
    assign mem_addr_o = {2'b00, addr_q[XLEN-1:2]};
    assign dbg_state  = state;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state        <= IDLE;
            req_ready_o  <= 1'b1;
            resp_valid_o <= 1'b0;
            resp_rdata_o <= '0;
            resp_err_o   <= 1'b0;
            mem_we_o     <= 1'b0;
            mem_wdata_o  <= '0;
            store_q      <= 1'b0;
            funct3_q     <= 3'b000;
            addr_q       <= '0;
            wdata_q      <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid_i && req_ready_o) begin
                        store_q     <= req_store_i;
                        funct3_q    <= req_funct3_i;
                        addr_q      <= req_addr_i;
                        wdata_q     <= req_wdata_i;
                        req_ready_o <= 1'b0;
                        if (is_illegal(req_store_i, req_funct3_i) ||
                            is_misaligned(req_funct3_i, req_addr_i[1:0])) begin
                            state <= ERR;
                        end else if (req_store_i && (req_funct3_i != F3_W)) begin
                            state <= RMW_RD;
                        end else begin
                            // SW writes during ACCESS; loads only read.
                            state    <= ACCESS;
                            mem_we_o <= req_store_i;
                            if (req_store_i) mem_wdata_o <= req_wdata_i;
                        end
                    end
                end
                ACCESS: begin
                    mem_we_o     <= 1'b0;
                    resp_rdata_o <= store_q ? '0 : load_data;
                    resp_err_o   <= 1'b0;
                    resp_valid_o <= 1'b1;
                    state        <= RESP;
                end
                RMW_RD: begin
                    // Merged word is registered straight into the write-data port.
                    mem_wdata_o <= merged;
                    mem_we_o    <= 1'b1;
                    state       <= RMW_WR;
                end
                RMW_WR: begin
                    mem_we_o     <= 1'b0;
                    resp_rdata_o <= '0;
                    resp_err_o   <= 1'b0;
                    resp_valid_o <= 1'b1;
                    state        <= RESP;
                end
                ERR: begin
                    mem_we_o     <= 1'b0;
                    resp_rdata_o <= '0;
                    resp_err_o   <= 1'b1;
                    resp_valid_o <= 1'b1;
                    state        <= RESP;
                end
                RESP: begin
                    resp_valid_o <= 1'b0;
                    req_ready_o  <= 1'b1;
                    state        <= IDLE;
                end
                default: begin
                    mem_we_o     <= 1'b0;
                    resp_valid_o <= 1'b0;
                    req_ready_o  <= 1'b1;
                    state        <= IDLE;
                end
            endcase
        end
    end

endmodule
